// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD up/down timer controller (00-99).
// Ports:
//   clk, clr_n         : clock (rising edge), async active-low reset
//   start, stop        : run / pause requests (stop has priority)
//   up_d               : direction request, sampled when entering RUN
//   load, load_val     : preset strobe and BCD preset value (outside RUN only)
//   units, tens        : current digit values
//   step_u, step_t     : one-cycle step strobes for units / tens digits
//   dir, busy, done    : latched direction, RUN indicator, DONE-entry pulse
//   state              : IDLE=0, RUN=1, PAUSE=2, DONE=3
module bcd_timer_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       stop,
  input  logic       up_d,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       step_u,
  output logic       step_t,
  output logic       dir,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_d;
  logic [3:0]    units_d, tens_d;
  logic [7:0]    preset, preset_d;
  logic [PW-1:0] presc, presc_d;
  logic          dir_d, step_u_d, step_t_d, done_d;
  logic          at_term, step_term;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Value already at the end of the count for the latched direction.
  assign at_term = dir ? (units == 4'd9 && tens == 4'd9)
                       : (units == 4'd0 && tens == 4'd0);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    units_d   = units;
    tens_d    = tens;
    preset_d  = preset;
    presc_d   = presc;
    dir_d     = dir;
    step_u_d  = 1'b0;
    step_t_d  = 1'b0;
    done_d    = 1'b0;
    step_term = 1'b0;

    case (state)
      S_RUN: begin
        if (at_term) begin
          // Entered RUN already terminal: finish without stepping.
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (presc == PLAST) begin
          presc_d  = '0;
          step_u_d = 1'b1;
          if (dir) begin
            if (units == 4'd9) begin
              units_d  = 4'd0;
              tens_d   = tens + 4'd1;
              step_t_d = 1'b1;
            end else begin
              units_d = units + 4'd1;
            end
          end else begin
            if (units == 4'd0) begin
              units_d  = 4'd9;
              tens_d   = tens - 4'd1;
              step_t_d = 1'b1;
            end else begin
              units_d = units - 4'd1;
            end
          end
          step_term = dir ? (units_d == 4'd9 && tens_d == 4'd9)
                          : (units_d == 4'd0 && tens_d == 4'd0);
          // Reaching terminal takes precedence over a concurrent stop.
          if (step_term) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (stop) begin
            state_d = S_PAUSE;
          end
        end else begin
          presc_d = presc + PW'(1);
          if (stop) state_d = S_PAUSE;
        end
      end
      default: begin
        // IDLE, PAUSE, DONE: load wins over start for this edge.
        if (load) begin
          units_d  = clamp9(load_val[3:0]);
          tens_d   = clamp9(load_val[7:4]);
          preset_d = {tens_d, units_d};
        end else if (start && !stop) begin
          state_d = S_RUN;
          if (state == S_IDLE) begin
            dir_d   = up_d;
            presc_d = '0;
          end else if (state == S_DONE) begin
            units_d = preset[3:0];
            tens_d  = preset[7:4];
            dir_d   = up_d;
            presc_d = '0;
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= S_IDLE;
      units  <= 4'd0;
      tens   <= 4'd0;
      preset <= 8'd0;
      presc  <= '0;
      dir    <= 1'b1;
      step_u <= 1'b0;
      step_t <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      units  <= units_d;
      tens   <= tens_d;
      preset <= preset_d;
      presc  <= presc_d;
      dir    <= dir_d;
      step_u <= step_u_d;
      step_t <= step_t_d;
      busy   <= (state_d == S_RUN);
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl: directed scenarios followed by
// random control traffic, all compared every cycle against a value-level model.
module tb_bcd_timer_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, up_d = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] units, tens;
  logic       step_u, step_t, dir, busy, done;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // Reference model: count held as an integer 0..99.
  int m_state, m_val, m_preset, m_dir, m_ph, m_step_u, m_step_t, m_done;

  bcd_timer_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .up_d(up_d),
    .load(load), .load_val(load_val), .units(units), .tens(tens),
    .step_u(step_u), .step_t(step_t), .dir(dir), .busy(busy), .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_val = 0; m_preset = 0; m_dir = 1; m_ph = 0;
    m_step_u = 0; m_step_t = 0; m_done = 0;
  endtask

  function automatic int clamp_bcd(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]); lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic bit is_end(input int v, input int d);
    return (d != 0) ? (v == 99) : (v == 0);
  endfunction

  // One clock edge of the intended behaviour, using current inputs.
  task automatic model_edge();
    int old;
    m_step_u = 0; m_step_t = 0; m_done = 0;
    if (m_state == 1) begin
      if (is_end(m_val, m_dir)) begin
        m_state = 3; m_done = 1;
      end else if (m_ph == DIV - 1) begin
        m_ph = 0;
        old = m_val;
        m_val = (m_dir != 0) ? m_val + 1 : m_val - 1;
        m_step_u = 1;
        m_step_t = (old / 10 != m_val / 10) ? 1 : 0;
        if (is_end(m_val, m_dir)) begin
          m_state = 3; m_done = 1;
        end else if (stop) m_state = 2;
      end else begin
        m_ph++;
        if (stop) m_state = 2;
      end
    end else if (load) begin
      m_val = clamp_bcd(load_val);
      m_preset = m_val;
    end else if (start && !stop) begin
      if (m_state == 0) begin
        m_dir = int'(up_d); m_ph = 0;
      end else if (m_state == 3) begin
        m_val = m_preset; m_dir = int'(up_d); m_ph = 0;
      end
      m_state = 1;
    end
  endtask

  task automatic compare_all();
    check("units", int'(units), m_val % 10);
    check("tens", int'(tens), m_val / 10);
    check("step_u", int'(step_u), m_step_u);
    check("step_t", int'(step_t), m_step_t);
    check("dir", int'(dir), m_dir);
    check("busy", int'(busy), (m_state == 1) ? 1 : 0);
    check("done", int'(done), m_done);
    check("state", int'(state), m_state);
  endtask

  // Called at a negedge: apply inputs, clock once, check at the next negedge.
  task automatic drive(input bit st, input bit sp, input bit ud, input bit ld,
                       input logic [7:0] lv);
    start = st; stop = sp; up_d = ud; load = ld; load_val = lv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset applied between edges, released at a negedge.
  task automatic do_reset();
    clr_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    clr_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Count up 07 -> 10 across a carry.
    drive(0, 0, 1, 1, 8'h07);
    drive(1, 0, 1, 0, 8'h00);
    repeat (12) drive(0, 0, 1, 0, 8'h00);

    // Pause, load 97, resume to 99 / DONE.
    drive(0, 1, 1, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h97);
    drive(1, 0, 1, 0, 8'h00);
    repeat (12) drive(0, 0, 1, 0, 8'h00);

    // Count down 11 -> 00, then restart from preset.
    drive(0, 0, 0, 1, 8'h11);
    drive(1, 0, 0, 0, 8'h00);
    repeat (48) drive(0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    repeat (5) drive(0, 0, 0, 0, 8'h00);

    // Pause mid-phase, hold, resume with phase kept.
    drive(0, 1, 0, 0, 8'h00);
    repeat (10) drive(0, 0, 1, 0, 8'h00);
    drive(1, 0, 1, 0, 8'h00);
    repeat (6) drive(0, 0, 1, 0, 8'h00);

    // Start at terminal (00 down), clamped load, load ignored in RUN.
    drive(0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    repeat (3) drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 1, 1, 8'hAB);
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h12);
    repeat (6) drive(0, 0, 0, 0, 8'h00);

    // Reset mid-run, then start+stop together in IDLE.
    do_reset();
    drive(1, 1, 1, 0, 8'h00);
    drive(1, 1, 1, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h42);
    drive(1, 0, 1, 0, 8'h00);
    repeat (5) drive(0, 0, 1, 0, 8'h00);
    do_reset();

    // Random control traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(699, 0) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(99, 0) < 25),
              ($urandom_range(99, 0) < ((m_state == 1) ? 3 : 15)),
              1'($urandom),
              ($urandom_range(99, 0) < 8),
              8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
